// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one decoder-based full adder cell reused over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; outputs hold the last result
//   RUN   | one operand bit pair per cycle through the adder cell
//   DONE  | done pulse; a start here is accepted exactly as in IDLE

module full_adder_usingdecoder (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic s,
   output logic c
);
   logic [7:0] dec;

   // Minterm decode of {x,y,z}; sum and carry are ORs of their minterms.
   always_comb begin
      dec = 8'b0;
      dec[{x, y, z}] = 1'b1;
   end

   assign s = dec[1] | dec[2] | dec[4] | dec[7];
   assign c = dec[3] | dec[5] | dec[6] | dec[7];
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] a_sh, b_sh, res_sh, sum_r;
   logic             carry_r, cout_r, done_r;
   logic [CW-1:0]    bit_cnt;
   logic             cell_s, cell_c;
   logic             accept;
   logic             last_bit;
   logic [WIDTH-1:0] res_nxt;

   full_adder_usingdecoder u_fa (
      .x (a_sh[0]),
      .y (b_sh[0]),
      .z (carry_r),
      .s (cell_s),
      .c (cell_c)
   );

   assign accept   = start && ((state == IDLE) || (state == DONE));
   assign last_bit = (bit_cnt == LAST);
   assign res_nxt  = {cell_s, res_sh[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         sum_r   <= '0;
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         done_r  <= 1'b0;
         bit_cnt <= '0;
      end else begin
         done_r <= 1'b0;
         if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_r <= cin;
            bit_cnt <= '0;
         end else if (state == RUN) begin
            res_sh  <= res_nxt;
            carry_r <= cell_c;
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            // Counter parks on the last bit instead of wrapping.
            if (last_bit) begin
               sum_r  <= res_nxt;
               cout_r <= cell_c;
               done_r <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   logic ovf_r;

   // carry_r before the final update is the carry into the MSB.
   always_ff @(posedge clk) begin
      if (rst)                            ovf_r <= 1'b0;
      else if (state == RUN && last_bit) ovf_r <= carry_r ^ cell_c;
   end

   assign ovf = ovf_r;
`endif

   assign busy = (state == RUN);
   assign done = done_r;
   assign sum  = sum_r;
   assign cout = cout_r;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8); checks ovf when SERIAL_ADD_OVF_EN is defined.
module tb_serial_adder_ctrl;
   logic       clk = 1'b0;
   logic       rst, start, cin;
   logic [7:0] a, b;
   logic       busy, done, cout;
   logic [7:0] sum;
`ifdef SERIAL_ADD_OVF_EN
   logic       ovf;
`endif
   int checks = 0;
   int failures = 0;

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Start in the current cycle T, then verify busy/done timing and the result at T+9.
   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         input logic [7:0] esum, input logic ecout, input logic eovf);
      a = ia; b = ib; cin = ic; start = 1'b1;
      tick();
      start = 1'b0;
      a = ~ia;
      for (int i = 1; i <= 8; i++) begin
         chk("run_busy", {31'b0, busy}, 32'd1);
         chk("run_nodone", {31'b0, done}, 32'd0);
         tick();
      end
      chk("fin_done", {31'b0, done}, 32'd1);
      chk("fin_busy", {31'b0, busy}, 32'd0);
      chk("fin_sum", {24'b0, sum}, {24'b0, esum});
      chk("fin_cout", {31'b0, cout}, {31'b0, ecout});
`ifdef SERIAL_ADD_OVF_EN
      chk("fin_ovf", {31'b0, ovf}, {31'b0, eovf});
`else
      if (eovf !== 1'b0 && eovf !== 1'b1) $display("ovf expectation undefined");
`endif
      tick();
      chk("after_done", {31'b0, done}, 32'd0);
      chk("held_sum", {24'b0, sum}, {24'b0, esum});
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
      tick(); tick();
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_sum", {24'b0, sum}, 32'd0);
      chk("rst_cout", {31'b0, cout}, 32'd0);
      rst = 1'b0;
      tick();

      run_op(8'h3C, 8'h25, 1'b0, 8'h61, 1'b0, 1'b0);
      run_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

      // Back-to-back with start held high; only cycles T and T+9 are accepted.
      a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      tick();
      a = 8'hFF; b = 8'hFF; cin = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk("b2b_busy1", {31'b0, busy}, 32'd1);
         tick();
      end
      a = 8'hA0; b = 8'h70; cin = 1'b1;
      chk("b2b_done1", {31'b0, done}, 32'd1);
      chk("b2b_idle1", {31'b0, busy}, 32'd0);
      chk("b2b_sum1", {24'b0, sum}, 32'h46);
      chk("b2b_cout1", {31'b0, cout}, 32'd0);
      tick();
      a = 8'hFF; b = 8'hFF; cin = 1'b1;
      for (int i = 10; i <= 17; i++) begin
         chk("b2b_busy2", {31'b0, busy}, 32'd1);
         chk("b2b_nodone", {31'b0, done}, 32'd0);
         tick();
      end
      start = 1'b0;
      chk("b2b_done2", {31'b0, done}, 32'd1);
      chk("b2b_sum2", {24'b0, sum}, 32'h11);
      chk("b2b_cout2", {31'b0, cout}, 32'd1);
      tick();
      chk("b2b_stop", {31'b0, busy}, 32'd0);

      // Operand change mid-RUN must not disturb the result.
      a = 8'h55; b = 8'h0A; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      a = 8'hAA; b = 8'hF0; cin = 1'b1;
      for (int i = 3; i <= 8; i++) tick();
      chk("mid_done", {31'b0, done}, 32'd1);
      chk("mid_sum", {24'b0, sum}, 32'h5F);
      chk("mid_cout", {31'b0, cout}, 32'd0);
      tick();

      // Reset at T+4 aborts the operation.
      a = 8'hC0; b = 8'hC0; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_sum", {24'b0, sum}, 32'd0);
      chk("abort_cout", {31'b0, cout}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         chk("abort_nodone", {31'b0, done}, 32'd0);
         tick();
      end
      run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

      run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences a single decoder-based 1-bit full adder cell (`full_adder_usingdecoder`) over WIDTH cycles to add two WIDTH-bit operands. A start/busy/done handshake accepts one operation at a time. The block latches the operands, shifts them LSB-first through the shared adder cell, and registers the carry between bits. It assembles the result in a shift register. This is the area-minimal adder option for the arithmetic labs, in place of a WIDTH-bit ripple array.

## Interface
- `WIDTH`, default 8: operand and result width, range 2..32.
- `clk`, input, 1: rising-edge clock; the only clock.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a new addition; sampled only when the block is not busy.
- `a`, input, WIDTH: operand A; sampled with `start`.
- `b`, input, WIDTH: operand B; sampled with `start`.
- `cin`, input, 1: initial carry; sampled with `start`.
- `busy`, output, 1: high while bits are being processed.
- `done`, output, 1: single-cycle pulse; `sum` and `cout` are valid.
- `sum`, output, WIDTH: result; held until the next accepted `start`.
- `cout`, output, 1: final carry out; held with `sum`.
- `ovf`, output, 1: signed overflow. Present only when the configuration macro is defined.

## Operation
- **FSM states.** IDLE, RUN, DONE.
  - IDLE: `start`=1 latches `a`, `b`, `cin` into `a_sh`, `b_sh`, `carry_r`; clears `bit_cnt`; goes to RUN.
  - RUN: the adder cell input is {`a_sh[0]`, `b_sh[0]`, `carry_r`} (MSB to LSB). Each cycle:
    - The cell sum is shifted into the MSB of `res_sh` (shift right).
    - `carry_r` takes the cell carry.
    - `a_sh` and `b_sh` shift right by 1.
    - `bit_cnt` increments.
    - When `bit_cnt` = WIDTH-1, the FSM goes to DONE after this cycle's update.
  - DONE: `done`=1 for this one cycle; `sum` = `res_sh`; `cout` = `carry_r`. If `start`=1 in this cycle, a new operation is accepted exactly as in IDLE and the FSM goes to RUN. Otherwise it goes to IDLE.
- **Handshake.** `start` is ignored while `busy`=1; there is no queuing. `a`, `b`, `cin` may change freely after acceptance.
- **Arithmetic.** Unsigned modulo 2^WIDTH. `{cout,sum}` = `a` + `b` + `cin`. Signed overflow = carry into the MSB XOR `cout`.
- **Counter.** `bit_cnt` width is $clog2(WIDTH); it never wraps past WIDTH-1.
- **Reset.** `rst` overrides everything, including mid-RUN. On reset:
  - The FSM goes to IDLE.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0 (and `ovf`=0).
  - All shift registers, `carry_r` and `bit_cnt` are 0.
  - An operation aborted by reset produces no `done`.

## Timing
- Let cycle T be the cycle in which `start` is sampled high from IDLE or DONE.
- `busy` is high in cycles T+1 through T+WIDTH, and low in all other cycles.
- `done` is high in cycle T+WIDTH+1 only.
- `sum` and `cout` update at the edge ending cycle T+WIDTH and are stable from T+WIDTH+1 until the edge following the next accepted `start` + WIDTH.
- Throughput: one addition every WIDTH+1 cycles with back-to-back `start`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SERIAL_ADD_OVF_EN`.
- **Defined.** Port `ovf` exists.
  - The block registers `carry_r` as it was before the final RUN cycle's update (the carry into the MSB).
  - In DONE, `ovf` = that registered MSB carry-in XOR `cout`.
  - `ovf` is held with `sum`.
- **Undefined.** No `ovf` port and no extra register. All other behaviour is identical.

## Test plan
- **Reset values.** Assert `rst` for 2 cycles → `busy`=0, `done`=0, `sum`=0x00, `cout`=0.
- **Basic add (WIDTH=8).** `a`=0x3C, `b`=0x25, `cin`=0, pulse `start` in cycle T → `busy` high T+1..T+8; `done` pulse at T+9 with `sum`=0x61, `cout`=0.
- **Carry out and cin.** `a`=0xFF, `b`=0x00, `cin`=1 → `sum`=0x00, `cout`=1. Then `a`=0xFF, `b`=0xFF, `cin`=1 → `sum`=0xFF, `cout`=1.
- **Busy and back-to-back.**
  - Hold `start` high continuously with new operands each cycle. Required response:
    - Only the values present in cycles T and T+9 are accepted.
    - `done` occurs at T+9 and T+18.
    - `busy` is low only during the DONE cycles.
  - In a separate run, change `a` mid-RUN → result is unaffected.
- **Reset mid-operation.** Assert `rst` at T+4 → no `done` appears, and outputs are zero. A following `start` with `a`=0x01, `b`=0x01 → `sum`=0x02 at 9 cycles.
- **Overflow (SERIAL_ADD_OVF_EN).**
  - `a`=0x7F, `b`=0x01 → `ovf`=1, `cout`=0.
  - `a`=0x80, `b`=0x80 → `ovf`=1, `cout`=1.
  - `a`=0xFF, `b`=0x01 → `ovf`=0, `cout`=1.
